// File: rtl/conv_unit_scheduler.sv
// conv_unit_scheduler
//   Sequencer for a D x D convolutional PE mesh. Accepts one layer job
//   (kernel size K, input width IW, output rows OH) over a valid/ready
//   handshake. It steps through every output row and every D-wide column
//   tile of that row. For each tile it spends K cycles in RUN, one per kernel
//   column kc, and then waits in OUT until the accumulation buffer takes the
//   finished tile.
//
// Ports
//   CLK, RSTn            clock (rising edge), asynchronous active-low reset
//   job_valid/job_ready  job descriptor handshake (job_k, job_iw, job_oh)
//   job_err              one-cycle pulse when an illegal job is rejected
//   columnControl        7 bits per column: {3'b0, col_active, psum_shift,
//                        acc_clear, mac_en}
//   rowControl           per-row {row_used, row_index}
//   commonControl        {IW, OW, K-1, kc}
//   kbuf_addr            kernel column index kc
//   nbuf_row, nbuf_col   neuron buffer address (row, tile*D + kc)
//   psum_valid/ready     finished-tile handshake toward accumulation buffer
//   busy, done           job in progress / one-cycle completion pulse
//
// Every output is decoded from flops only. The one exception is psum_shift,
// which is qualified by psum_ready in the same cycle so that the mesh shifts
// exactly on the handshake cycle.
module conv_unit_scheduler #(
    parameter int depth = 2,
    parameter int D     = 1 << depth,
    parameter int A     = 7
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [depth:0]         job_k,
    input  logic [A-1:0]           job_iw,
    input  logic [A-1:0]           job_oh,
    output logic                   job_err,
    output logic [D*7-1:0]         columnControl,
    output logic [(depth+1)*D-1:0] rowControl,
    output logic [2*depth+2*A-1:0] commonControl,
    output logic [depth-1:0]       kbuf_addr,
    output logic [A-1:0]           nbuf_row,
    output logic [A-1:0]           nbuf_col,
    output logic                   psum_valid,
    input  logic                   psum_ready,
    output logic                   busy,
    output logic                   done
);
    // Wide enough for tile*D + D without wrapping.
    localparam int W = A + depth + 1;

    typedef enum logic [2:0] {IDLE, CFG, RUN, OUT, FIN} state_t;

    state_t           state_q, state_d;
    logic [depth:0]   k_q, k_d;
    logic [A-1:0]     iw_q, iw_d;
    logic [A-1:0]     oh_q, oh_d;
    logic [A-1:0]     row_q, row_d;
    logic [A-1:0]     tile_q, tile_d;
    logic [depth-1:0] kc_q, kc_d;
    logic             err_q, err_d;

    logic [A-1:0]     ow;
    logic [W-1:0]     tile_base;
    logic [W-1:0]     next_base;
    logic [depth:0]   k_m1;
    logic             last_kc;
    logic             in_job;
    logic             job_bad;
    logic [D-1:0]     active;

    always_comb begin
        ow        = iw_q - A'(k_q) + A'(1);
        tile_base = W'(tile_q) << depth;
        next_base = tile_base + W'(D);
        k_m1      = k_q - 1'b1;
        last_kc   = ({1'b0, kc_q} == k_m1);
        in_job    = (state_q == CFG) || (state_q == RUN) || (state_q == OUT);
        job_bad   = (job_k == '0) || (job_k > (depth+1)'(D)) ||
                    (job_oh == '0) || (job_iw < A'(job_k));
        // The last tile of a row can overhang OW; those columns stay idle.
        for (int j = 0; j < D; j++) begin
            active[j] = in_job && ((tile_base + W'(j)) < W'(ow));
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        iw_d    = iw_q;
        oh_d    = oh_q;
        row_d   = row_q;
        tile_d  = tile_q;
        kc_d    = kc_q;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                row_d  = '0;
                tile_d = '0;
                kc_d   = '0;
                if (job_valid) begin
                    k_d  = job_k;
                    iw_d = job_iw;
                    oh_d = job_oh;
                    if (job_bad) err_d   = 1'b1;
                    else         state_d = CFG;
                end
            end
            CFG: begin
                row_d   = '0;
                tile_d  = '0;
                kc_d    = '0;
                state_d = RUN;
            end
            RUN: begin
                if (last_kc) state_d = OUT;
                else         kc_d    = kc_q + 1'b1;
            end
            OUT: begin
                if (psum_ready) begin
                    if (next_base < W'(ow)) begin
                        tile_d  = tile_q + 1'b1;
                        kc_d    = '0;
                        state_d = RUN;
                    end else if ((W'(row_q) + W'(1)) < W'(oh_q)) begin
                        row_d   = row_q + 1'b1;
                        tile_d  = '0;
                        kc_d    = '0;
                        state_d = RUN;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                // Clear the counters so the addresses read zero in IDLE.
                row_d   = '0;
                tile_d  = '0;
                kc_d    = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            k_q     <= '0;
            iw_q    <= '0;
            oh_q    <= '0;
            row_q   <= '0;
            tile_q  <= '0;
            kc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            iw_q    <= iw_d;
            oh_q    <= oh_d;
            row_q   <= row_d;
            tile_q  <= tile_d;
            kc_q    <= kc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        columnControl = '0;
        rowControl    = '0;
        commonControl = '0;
        for (int j = 0; j < D; j++) begin
            columnControl[j*7 +: 7] = {3'b000,
                                       active[j],
                                       (state_q == OUT) && psum_ready && active[j],
                                       (state_q == RUN) && active[j] && (kc_q == '0),
                                       (state_q == RUN) && active[j]};
        end
        if (state_q != IDLE) begin
            for (int i = 0; i < D; i++) begin
                rowControl[i*(depth+1) +: (depth+1)] = {((depth+1)'(i) < k_q), depth'(i)};
            end
            commonControl = {iw_q, ow, k_m1[depth-1:0], kc_q};
        end
    end

    assign job_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign psum_valid = (state_q == OUT);
    assign job_err    = err_q;
    assign kbuf_addr  = kc_q;
    assign nbuf_row   = row_q;
    assign nbuf_col   = A'(tile_base + W'(kc_q));

endmodule

// File: tb/tb_conv_unit_scheduler.sv
// Testbench for conv_unit_scheduler (depth=2, D=4, A=7).
// The expected RUN-cycle addresses and tile masks come from a reference model
// of the loop nest. They are queued when a job is submitted. A monitor pops
// them when the DUT shows a RUN cycle or a tile handshake.
module tb_conv_unit_scheduler;
    localparam int DEPTH = 2;
    localparam int D     = 4;
    localparam int A     = 7;

    typedef struct {
        int       kc;
        int       row;
        int       col;
        logic [D-1:0] mask;
    } run_e_t;

    typedef struct {
        int       row;
        logic [D-1:0] mask;
    } tile_e_t;

    logic                   CLK = 1'b0;
    logic                   RSTn = 1'b0;
    logic                   job_valid = 1'b0;
    logic                   job_ready;
    logic [DEPTH:0]         job_k = '0;
    logic [A-1:0]           job_iw = '0;
    logic [A-1:0]           job_oh = '0;
    logic                   job_err;
    logic [D*7-1:0]         columnControl;
    logic [(DEPTH+1)*D-1:0] rowControl;
    logic [2*DEPTH+2*A-1:0] commonControl;
    logic [DEPTH-1:0]       kbuf_addr;
    logic [A-1:0]           nbuf_row;
    logic [A-1:0]           nbuf_col;
    logic                   psum_valid;
    logic                   psum_ready = 1'b1;
    logic                   busy;
    logic                   done;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    run_e_t  run_q[$];
    tile_e_t tile_q[$];

    logic [D-1:0]   mac_m, clr_m, shf_m, act_m;
    logic [3*D-1:0] hi_m;

    conv_unit_scheduler #(.depth(DEPTH), .D(D), .A(A)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_k(job_k), .job_iw(job_iw), .job_oh(job_oh), .job_err(job_err),
        .columnControl(columnControl), .rowControl(rowControl),
        .commonControl(commonControl),
        .kbuf_addr(kbuf_addr), .nbuf_row(nbuf_row), .nbuf_col(nbuf_col),
        .psum_valid(psum_valid), .psum_ready(psum_ready),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        mac_m = '0; clr_m = '0; shf_m = '0; act_m = '0; hi_m = '0;
        for (int j = 0; j < D; j++) begin
            mac_m[j]       = columnControl[j*7];
            clr_m[j]       = columnControl[j*7+1];
            shf_m[j]       = columnControl[j*7+2];
            act_m[j]       = columnControl[j*7+3];
            hi_m[j*3 +: 3] = columnControl[j*7+4 +: 3];
        end
    end

    // Scoreboard monitor: column 0 is active in every RUN cycle of every tile.
    always @(negedge CLK) begin
        run_e_t  re;
        tile_e_t te;
        logic [D-1:0] clr_exp;
        if (RSTn && mon_en) begin
            if (mac_m[0]) begin
                tests++;
                if (run_q.size() == 0) begin
                    fails++;
                    $display("FAIL run_unexpected: RUN cycle with kbuf_addr=%0d nbuf_col=%0d but none expected",
                             kbuf_addr, nbuf_col);
                end else begin
                    re = run_q.pop_front();
                    clr_exp = (re.kc == 0) ? re.mask : '0;
                    if ({kbuf_addr, nbuf_row, nbuf_col, mac_m, clr_m, hi_m} !==
                        {DEPTH'(re.kc), A'(re.row), A'(re.col), re.mask, clr_exp, 12'b0}) begin
                        fails++;
                        $display("FAIL run_cycle: got kc=%0d row=%0d col=%0d mac=%b clr=%b hi=%h, need kc=%0d row=%0d col=%0d mac=%b clr=%b hi=0",
                                 kbuf_addr, nbuf_row, nbuf_col, mac_m, clr_m, hi_m,
                                 re.kc, re.row, re.col, re.mask, clr_exp);
                    end
                end
            end
            if (psum_valid && psum_ready) begin
                tests++;
                if (tile_q.size() == 0) begin
                    fails++;
                    $display("FAIL tile_unexpected: tile handshake with mask=%b but none expected", act_m);
                end else begin
                    te = tile_q.pop_front();
                    if ({act_m, shf_m, nbuf_row} !== {te.mask, te.mask, A'(te.row)}) begin
                        fail_tile(act_m, shf_m, nbuf_row, te.mask, te.row);
                    end
                end
            end
        end
    end

    task automatic fail_tile(input logic [D-1:0] act, input logic [D-1:0] shf,
                             input logic [A-1:0] row, input logic [D-1:0] m, input int r);
        fails++;
        $display("FAIL tile_out: got active=%b shift=%b row=%0d, need active=%b shift=%b row=%0d",
                 act, shf, row, m, m, r);
    endtask

    task automatic push_model(input int k, input int iw, input int oh);
        int ow;
        int ntile;
        run_e_t re;
        tile_e_t te;
        logic [D-1:0] m;
        ow = iw - k + 1;
        ntile = (ow + D - 1) / D;
        for (int r = 0; r < oh; r++) begin
            for (int t = 0; t < ntile; t++) begin
                m = '0;
                for (int j = 0; j < D; j++) if (t*D + j < ow) m[j] = 1'b1;
                for (int kc = 0; kc < k; kc++) begin
                    re.kc = kc; re.row = r; re.col = (t*D + kc) % 128; re.mask = m;
                    run_q.push_back(re);
                end
                te.row = r; te.mask = m;
                tile_q.push_back(te);
            end
        end
    endtask

    task automatic submit(input int k, input int iw, input int oh);
        @(posedge CLK); #1;
        job_k = 3'(k); job_iw = 7'(iw); job_oh = 7'(oh); job_valid = 1'b1;
        @(posedge CLK); #1;
        job_valid = 1'b0;
    endtask

    task automatic run_to_done(input int budget, output int first_run, output int psum_cnt,
                               output int last_out, output int done_cyc);
        first_run = 0; psum_cnt = 0; last_out = 0; done_cyc = 0;
        for (int c = 1; c <= budget; c++) begin
            @(negedge CLK);
            if (mac_m[0] && first_run == 0) first_run = c;
            if (psum_valid) begin psum_cnt++; last_out = c; end
            if (done) begin done_cyc = c; break; end
        end
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        tests++;
        if ({job_ready, job_err, psum_valid, busy, done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_ctrl: got ready/err/pv/busy/done=%b, need 10000",
                     {job_ready, job_err, psum_valid, busy, done});
        end
        tests++;
        if ({columnControl, rowControl, commonControl, kbuf_addr, nbuf_row, nbuf_col} !== '0) begin
            fails++;
            $display("FAIL reset_bus: got col=%h row=%h com=%h kb=%0d nr=%0d nc=%0d, need all 0",
                     columnControl, rowControl, commonControl, kbuf_addr, nbuf_row, nbuf_col);
        end
        @(posedge CLK); #1;
        RSTn = 1'b1;
        mon_en = 1'b1;
        @(negedge CLK);
        tests++;
        if ({job_ready, busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_release: got ready/busy=%b, need 10", {job_ready, busy});
        end
    endtask

    task automatic test_basic();
        int fr, pc, lo, dc;
        push_model(3, 6, 2);
        submit(3, 6, 2);
        @(negedge CLK);
        tests++;
        if ({busy, job_ready, mac_m, psum_valid} !== {1'b1, 1'b0, 4'b0000, 1'b0}) begin
            fails++;
            $display("FAIL basic_cfg_state: got busy=%b ready=%b mac=%b pv=%b, need 1 0 0000 0",
                     busy, job_ready, mac_m, psum_valid);
        end
        tests++;
        if ({commonControl, rowControl} !== {7'd6, 7'd4, 2'd2, 2'd0, 12'h7AC}) begin
            fails++;
            $display("FAIL basic_cfg_bus: got com=%h row=%h, need com=%h row=7ac",
                     commonControl, rowControl, {7'd6, 7'd4, 2'd2, 2'd0});
        end
        run_to_done(40, fr, pc, lo, dc);
        tests++;
        if ({fr, pc, lo, dc} !== {32'd1, 32'd2, 32'd8, 32'd9}) begin
            fails++;
            $display("FAIL basic_timing: got first_run=%0d psum_cycles=%0d last_out=%0d done=%0d, need 1 2 8 9",
                     fr, pc, lo, dc);
        end
        @(negedge CLK);
        tests++;
        if ({done, job_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL basic_done_pulse: got done/ready/busy=%b, need 010", {done, job_ready, busy});
        end
        tests++;
        if (run_q.size() + tile_q.size() != 0) begin
            fails++;
            $display("FAIL basic_drain: got %0d entries left, need 0", run_q.size() + tile_q.size());
        end
    endtask

    task automatic test_tiles();
        int fr, pc, lo, dc;
        push_model(3, 8, 1);
        submit(3, 8, 1);
        run_to_done(40, fr, pc, lo, dc);
        tests++;
        if ({fr, pc, dc} !== {32'd2, 32'd2, 32'd10}) begin
            fails++;
            $display("FAIL tiles_timing: got first_run=%0d psum_cycles=%0d done=%0d, need 2 2 10",
                     fr, pc, dc);
        end
        tests++;
        if (run_q.size() + tile_q.size() != 0) begin
            fails++;
            $display("FAIL tiles_drain: got %0d entries left, need 0", run_q.size() + tile_q.size());
        end
    endtask

    task automatic test_illegal();
        int ks[3]  = '{5, 0, 3};
        int iws[3] = '{6, 6, 2};
        for (int i = 0; i < 3; i++) begin
            submit(ks[i], iws[i], 2);
            @(negedge CLK);
            tests++;
            if ({job_err, busy, job_ready} !== 3'b101) begin
                fails++;
                $display("FAIL illegal_err_%0d: got err/busy/ready=%b, need 101", i, {job_err, busy, job_ready});
            end
            tests++;
            if ({columnControl, rowControl, commonControl} !== '0) begin
                fails++;
                $display("FAIL illegal_bus_%0d: got col=%h row=%h com=%h, need 0",
                         i, columnControl, rowControl, commonControl);
            end
            @(negedge CLK);
            tests++;
            if ({job_err, busy} !== 2'b00) begin
                fails++;
                $display("FAIL illegal_pulse_%0d: got err/busy=%b, need 00", i, {job_err, busy});
            end
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        seen = 1'b0;
        psum_ready = 1'b0;
        push_model(2, 5, 1);
        submit(2, 5, 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (psum_valid) begin seen = 1'b1; break; end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL bp_reach_out: got no psum_valid within 20 cycles, need psum_valid=1");
        end
        for (int c = 0; c < 5; c++) begin
            if (c != 0) @(negedge CLK);
            tests++;
            if ({psum_valid, busy, columnControl, commonControl[17:2], rowControl, nbuf_row} !==
                {1'b1, 1'b1, {4{7'h08}}, {7'd5, 7'd4, 2'd1}, 12'h6AC, 7'd0}) begin
                fails++;
                $display("FAIL bp_hold_%0d: got pv=%b col=%h com=%h row=%h nr=%0d, need pv=1 col=%h com[17:2]=%h row=6ac nr=0",
                         c, psum_valid, columnControl, commonControl, rowControl, nbuf_row,
                         {4{7'h08}}, {7'd5, 7'd4, 2'd1});
            end
        end
        @(posedge CLK); #1;
        psum_ready = 1'b1;
        #1;
        tests++;
        if ({psum_valid, shf_m} !== 5'b11111) begin
            fails++;
            $display("FAIL bp_shift: got pv=%b shift=%b, need 1 1111", psum_valid, shf_m);
        end
        @(negedge CLK);
        @(negedge CLK);
        tests++;
        if ({done, psum_valid} !== 2'b10) begin
            fails++;
            $display("FAIL bp_complete: got done/pv=%b, need 10", {done, psum_valid});
        end
        tests++;
        if (run_q.size() + tile_q.size() != 0) begin
            fails++;
            $display("FAIL bp_drain: got %0d entries left, need 0", run_q.size() + tile_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int fr, pc, lo, dc;
        push_model(3, 6, 2);
        submit(3, 6, 2);
        @(negedge CLK);
        @(negedge CLK);
        @(posedge CLK); #2;
        RSTn = 1'b0;
        #1;
        tests++;
        if ({job_ready, job_err, psum_valid, busy, done} !== 5'b10000) begin
            fails++;
            $display("FAIL rstmid_ctrl: got ready/err/pv/busy/done=%b, need 10000",
                     {job_ready, job_err, psum_valid, busy, done});
        end
        tests++;
        if ({columnControl, rowControl, commonControl, kbuf_addr, nbuf_row, nbuf_col} !== '0) begin
            fails++;
            $display("FAIL rstmid_bus: got col=%h row=%h com=%h kb=%0d nr=%0d nc=%0d, need all 0",
                     columnControl, rowControl, commonControl, kbuf_addr, nbuf_row, nbuf_col);
        end
        run_q.delete();
        tile_q.delete();
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(negedge CLK);
        tests++;
        if ({job_ready, busy, done} !== 3'b100) begin
            fails++;
            $display("FAIL rstmid_release: got ready/busy/done=%b, need 100", {job_ready, busy, done});
        end
        push_model(3, 8, 1);
        submit(3, 8, 1);
        run_to_done(40, fr, pc, lo, dc);
        tests++;
        if ({pc, dc} !== {32'd2, 32'd10}) begin
            fails++;
            $display("FAIL rstmid_rerun: got psum_cycles=%0d done=%0d, need 2 10", pc, dc);
        end
        tests++;
        if (run_q.size() + tile_q.size() != 0) begin
            fails++;
            $display("FAIL rstmid_drain: got %0d entries left, need 0", run_q.size() + tile_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int fr, pc, lo, dc;
        push_model(2, 5, 1);
        push_model(2, 5, 1);
        @(posedge CLK); #1;
        job_k = 3'd2; job_iw = 7'd5; job_oh = 7'd1; job_valid = 1'b1;
        @(posedge CLK); #1;
        run_to_done(30, fr, pc, lo, dc);
        tests++;
        if ({pc, dc} !== {32'd1, 32'd5}) begin
            fails++;
            $display("FAIL b2b_first: got psum_cycles=%0d done=%0d, need 1 5", pc, dc);
        end
        tests++;
        if ({run_q.size(), tile_q.size()} !== {32'd2, 32'd1}) begin
            fails++;
            $display("FAIL b2b_no_recapture: got run_left=%0d tile_left=%0d, need 2 1",
                     run_q.size(), tile_q.size());
        end
        @(negedge CLK);
        tests++;
        if ({job_ready, busy, done} !== 3'b100) begin
            fails++;
            $display("FAIL b2b_idle_gap: got ready/busy/done=%b, need 100", {job_ready, busy, done});
        end
        @(posedge CLK); #1;
        job_valid = 1'b0;
        run_to_done(30, fr, pc, lo, dc);
        tests++;
        if ({fr, pc, dc} !== {32'd2, 32'd1, 32'd5}) begin
            fails++;
            $display("FAIL b2b_second: got first_run=%0d psum_cycles=%0d done=%0d, need 2 1 5", fr, pc, dc);
        end
        tests++;
        if (run_q.size() + tile_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: got %0d entries left, need 0", run_q.size() + tile_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, need finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_tiles();
        test_illegal();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
